mprc_release_beat_queue: RTL

Registered FIFO directly downstream of the two-input Release locking arbiter in the non-blocking data cache. Accepts arbitrated Release beats and holds them until the outer TileLink network takes them, decoupling arbiter back-pressure from the network. Tracks multi-beat Release messages on the enqueue side, marks each message's final beat on the dequeue side, and optionally checks beat ordering.

---
 rtl/mprc_release_beat_queue_if.sv | 47 ++++
 rtl/mprc_release_beat_queue.sv | 102 ++++++++++
 2 files changed

// File: rtl/mprc_release_beat_queue_if.sv
// Handshake and status bundle between the Release arbiter, the beat queue and the network.
// slave = queue side, master = arbiter/network side.
interface mprc_release_beat_queue_if #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic          io_in_ready;
    logic          io_in_valid;
    logic [1:0]    io_in_bits_addr_beat;
    logic [25:0]   io_in_bits_addr_block;
    logic [1:0]    io_in_bits_client_xact_id;
    logic          io_in_bits_voluntary;
    logic [2:0]    io_in_bits_r_type;
    logic [127:0]  io_in_bits_data;
    logic          io_out_ready;
    logic          io_out_valid;
    logic [1:0]    io_out_bits_addr_beat;
    logic [25:0]   io_out_bits_addr_block;
    logic [1:0]    io_out_bits_client_xact_id;
    logic          io_out_bits_voluntary;
    logic [2:0]    io_out_bits_r_type;
    logic [127:0]  io_out_bits_data;
    logic          io_out_last;
    logic [CW-1:0] io_count;
    logic          io_msg_pending;
    logic          io_beat_err;

    modport slave (
        output io_in_ready,
        input  io_in_valid, io_in_bits_addr_beat, io_in_bits_addr_block,
               io_in_bits_client_xact_id, io_in_bits_voluntary, io_in_bits_r_type,
               io_in_bits_data, io_out_ready,
        output io_out_valid, io_out_bits_addr_beat, io_out_bits_addr_block,
               io_out_bits_client_xact_id, io_out_bits_voluntary, io_out_bits_r_type,
               io_out_bits_data, io_out_last, io_count, io_msg_pending, io_beat_err
    );

    modport master (
        input  io_in_ready,
        output io_in_valid, io_in_bits_addr_beat, io_in_bits_addr_block,
               io_in_bits_client_xact_id, io_in_bits_voluntary, io_in_bits_r_type,
               io_in_bits_data, io_out_ready,
        input  io_out_valid, io_out_bits_addr_beat, io_out_bits_addr_block,
               io_out_bits_client_xact_id, io_out_bits_voluntary, io_out_bits_r_type,
               io_out_bits_data, io_out_last, io_count, io_msg_pending, io_beat_err
    );
endinterface

// File: rtl/mprc_release_beat_queue.sv
// Registered Release beat FIFO between the Release arbiter and the outer network.
// Optional beat-ordering checker enabled by defining RELEASE_BEAT_CHECK_EN.
module mprc_release_beat_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input logic                         clk,
    input logic                         reset,
    mprc_release_beat_queue_if.slave    io
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + 26 + 2 + 1 + 3 + 128;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    in_beat;
    logic          full;
    logic          empty;
    logic          enq;
    logic          deq;
    logic          in_data;
    logic [EW-1:0] in_entry;
    logic [EW-1:0] head;

    // Ready/valid depend only on registered count: no ready-to-ready or in-to-out path.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign enq      = io.io_in_valid & ~full;
    assign deq      = io.io_out_ready & ~empty;
    assign in_data  = (io.io_in_bits_r_type <= 3'd2);

    assign io.io_in_ready    = ~full;
    assign io.io_out_valid   = ~empty;
    assign io.io_count       = count;
    assign io.io_msg_pending = (in_beat != 2'd0);

    assign in_entry = {io.io_in_bits_addr_beat, io.io_in_bits_addr_block,
                       io.io_in_bits_client_xact_id, io.io_in_bits_voluntary,
                       io.io_in_bits_r_type, io.io_in_bits_data};

    // Storage is intentionally not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    assign head = mem[rd_ptr];
    assign {io.io_out_bits_addr_beat, io.io_out_bits_addr_block,
            io.io_out_bits_client_xact_id, io.io_out_bits_voluntary,
            io.io_out_bits_r_type, io.io_out_bits_data} = head;

    assign io.io_out_last = ~empty & ((io.io_out_bits_r_type > 3'd2) |
                                      (io.io_out_bits_addr_beat == 2'd3));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            in_beat <= 2'd0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (enq && in_data) begin
                in_beat <= in_beat + 2'd1;
            end
        end
    end

`ifdef RELEASE_BEAT_CHECK_EN
    logic beat_err;
    logic beat_bad;

    // A data beat must carry the expected index; a non-data beat must not interrupt a message.
    assign beat_bad = in_data ? (io.io_in_bits_addr_beat != in_beat) : (in_beat != 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_err <= 1'b0;
        end else if (enq && beat_bad) begin
            beat_err <= 1'b1;
        end
    end

    assign io.io_beat_err = beat_err;
`else
    assign io.io_beat_err = 1'b0;
`endif

endmodule
